// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// product-word select codes and operand width.
package mul_arbiter_pkg;

   localparam int   OPW     = 16;
   localparam logic MODE_LO = 1'b0;
   localparam logic MODE_HI = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } state_t;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N with an explicit compare so non-power-of-two N works.
module rr_pick
   import mul_arbiter_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            valid,
   output logic [IDXW-1:0] idx
);

   // Scan from the farthest slot back to ptr so the nearest hit is written last.
   always_comb begin
      logic [IDXW:0] w_slot;
      valid  = 1'b0;
      idx    = '0;
      w_slot = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_slot = {1'b0, ptr} + (IDXW + 1)'(k);
         if (w_slot >= (IDXW + 1)'(N)) begin
            w_slot = w_slot - (IDXW + 1)'(N);
         end
         if (req[w_slot[IDXW-1:0]]) begin
            valid = 1'b1;
            idx   = w_slot[IDXW-1:0];
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one sequential 16x16 multiplier among N
// requesters, with a watchdog that aborts a hung multiply and reports err.
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int N       = 4,
   parameter int IDXW    = 2,
   parameter int TIMEOUT = 127
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         req_mode,
   input  logic [OPW*N-1:0]     req_a,
   input  logic [OPW*N-1:0]     req_b,
   output logic [N-1:0]         ack,
   output logic [N-1:0]         done,
   output logic [OPW-1:0]       res_data,
   output logic                 err,
   output logic                 busy,
   output logic                 mul_start,
   output logic                 mul_mode,
   output logic [OPW-1:0]       mul_num1,
   output logic [OPW-1:0]       mul_num2,
   input  logic [OPW-1:0]       mul_result,
   input  logic                 mul_rdy,
   input  logic                 mul_work
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   state_t          r_state;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] r_idx;
   logic [WDW-1:0]  r_wd;

   logic            w_pickValid;
   logic [IDXW-1:0] w_pickIdx;

   rr_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_pickValid),
      .idx   (w_pickIdx)
   );

   // The operand outputs double as the grant latches; strobes default low each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_idx     <= '0;
         r_wd      <= '0;
         ack       <= '0;
         done      <= '0;
         res_data  <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_mode  <= MODE_LO;
         mul_num1  <= '0;
         mul_num2  <= '0;
      end else begin
         ack       <= '0;
         done      <= '0;
         err       <= 1'b0;
         mul_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pickValid && !mul_work) begin
                  r_idx            <= w_pickIdx;
                  mul_num1         <= req_a[OPW*w_pickIdx +: OPW];
                  mul_num2         <= req_b[OPW*w_pickIdx +: OPW];
                  mul_mode         <= req_mode[w_pickIdx];
                  mul_start        <= 1'b1;
                  ack[w_pickIdx]   <= 1'b1;
                  busy             <= 1'b1;
                  r_state          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wd    <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A completion in the expiry cycle still wins over the abort.
               if (mul_rdy) begin
                  res_data    <= mul_result;
                  done[r_idx] <= 1'b1;
                  r_state     <= ST_DELIVER;
               end else if (r_wd == WDW'(TIMEOUT - 1)) begin
                  res_data    <= '0;
                  done[r_idx] <= 1'b1;
                  err         <= 1'b1;
                  r_state     <= ST_DELIVER;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            ST_DELIVER: begin
               r_ptr   <= (r_idx == IDXW'(N - 1)) ? '0 : r_idx + 1'b1;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin scheduler that shares one sequential shift-add 16x16 multiplier among N requesters.
- Accepts per-requester operand/mode requests and issues one multiply at a time via the multiplier's start/mode/num1/num2 interface.
- Captures the 16-bit result on the multiplier's rdy pulse and returns it to the granted requester with a one-cycle done strobe.
- Adds a watchdog so a hung multiplier cannot stall all requesters.

Parameters:
- N, 4, number of requesters (2..8)
- IDXW, 2, index width, $clog2(N)
- TIMEOUT, 127, max WAIT cycles before error abort (worst-case multiply is 65 cycles)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester request level; hold until ack
- req_mode  in  N  per-requester mode: 0 = low word of product, 1 = high word
- req_a  in  16*N  operand A, slice i = [16*i+15:16*i]
- req_b  in  16*N  operand B, same slicing
- ack  out  N  one-hot, 1-cycle pulse: request accepted, operands latched
- done  out  N  one-hot, 1-cycle pulse: res_data valid for that requester
- res_data  out  16  result, held until next DELIVER
- err  out  1  1-cycle pulse coincident with done on watchdog abort
- busy  out  1  high whenever FSM is not IDLE
- mul_start  out  1  start strobe to multiplier
- mul_mode  out  1  mode to multiplier
- mul_num1  out  16  operand A to multiplier
- mul_num2  out  16  operand B to multiplier
- mul_result  in  16  multiplier result, valid while mul_rdy = 1
- mul_rdy  in  1  multiplier completion pulse
- mul_work  in  1  multiplier busy

Behaviour:
- Reset: all outputs 0 (ack, done, err, busy, mul_start, mul_mode, mul_num1, mul_num2, res_data). State IDLE, rr pointer 0, watchdog 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - Grant only if |req and mul_work == 0.
  - Winner is the first set req bit searching from ptr upward, wrapping modulo N.
  - On grant: latch idx, a, b, mode; next state ISSUE.
- ISSUE (exactly 1 cycle):
  - mul_start = 1; mul_num1, mul_num2, mul_mode driven from latches.
  - ack[idx] = 1; next state WAIT; clear watchdog.
- WAIT:
  - mul_start = 0; operand outputs hold their values.
  - On mul_rdy: res_data <= mul_result; next state DELIVER.
  - Otherwise watchdog increments. When watchdog reaches TIMEOUT-1 with no mul_rdy: res_data <= 0, err flag set, next state DELIVER.
- DELIVER (1 cycle):
  - done[idx] = 1; err = flag; ptr <= (idx+1) mod N; clear flag; next state IDLE.
- Latency, grant edge to done, is 1 + 1 + multiplier latency + 1. Multiplier latency is 49..65 cycles: 3 per bit plus 1 per set bit of A, plus fin.
- The requester must drop req the cycle after ack. A req still high once FSM returns to IDLE is treated as a new request.
- req changes while not in IDLE are ignored. Operand changes after ack have no effect.
- Simultaneous requests: the lowest index at or above ptr wins.
- Starvation-free: each continuously requesting port is served within N transactions.
- mul_rdy outside WAIT is ignored. mul_rdy in the same cycle the watchdog expires counts as success (rdy has priority).
- Reset mid-operation returns to IDLE immediately; the in-flight result is discarded and no done is issued.
- N not a power of two: pointer wrap uses explicit compare, never rollover.

Decomposition:
- Shared package: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3), mode constants MODE_LO=0 and MODE_HI=1, operand width 16.
- Sub-module rr_pick: combinational, inputs req[N] and ptr[IDXW]; outputs valid and idx[IDXW].

Test Plan:
- Single request: req[2]=1, a=3, b=5, mode=0 → ack[2] 1 cycle after grant; done[2] with res_data=0x000F; err=0.
- High word: req[1], a=0x8000, b=0x0004, mode=1 → done[1], res_data=0x0002.
- Contention after reset: req[0] and req[3] set together, ptr=0 → port 0 served first (a=2, b=7 → 14), then port 3 (a=0x0010, b=0x0010 → 0x0100).
- Fairness: all 4 ports requesting continuously → done order 0,1,2,3,0,1; no port receives two dones before another is served.
- Watchdog: mul_rdy tied 0 with a single request on port 1 → after TIMEOUT WAIT cycles, done[1]=1, err=1, res_data=0; next request still served.
- Reset mid-WAIT: assert rst 10 cycles into WAIT → all outputs 0 immediately, no done; a new request after reset uses ptr=0 priority.
